// File: rtl/tcdm_xbar_pkg.sv
// Shared definitions for the pipelined TCDM crossbar.
//   resp_tag_t     : response pipeline entry {valid, initiator index, store flag}
//   bank_idx_width : bank select width for a given bank count
//   word_offset    : byte-offset bits within one data word
//   addr_bank      : bank selected by a byte address
//   addr_mem       : bank-local word address for a byte address
package tcdm_xbar_pkg;

  // Fixed upper bound on initiator index width so the tag type can live here.
  localparam int unsigned MaxIdxWidth = 8;

  typedef struct packed {
    logic                   valid;
    logic [MaxIdxWidth-1:0] idx;
    logic                   wen;
  } resp_tag_t;

  function automatic int unsigned bank_idx_width(input int unsigned num_out);
    return (num_out > 1) ? $clog2(num_out) : 1;
  endfunction

  function automatic int unsigned word_offset(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic logic [63:0] addr_bank(input logic [63:0]  addr,
                                            input int unsigned word_off,
                                            input int unsigned il_bits,
                                            input int unsigned bank_bits);
    return (addr >> (word_off + il_bits)) & ((64'd1 << bank_bits) - 64'd1);
  endfunction

  // Upper word bits above the bank field, followed by the in-bank interleave bits.
  function automatic logic [63:0] addr_mem(input logic [63:0]  addr,
                                           input int unsigned word_off,
                                           input int unsigned il_bits,
                                           input int unsigned bank_bits,
                                           input int unsigned mem_width);
    logic [63:0] word;
    word = addr >> word_off;
    return (((word >> (il_bits + bank_bits)) << il_bits) |
            (word & ((64'd1 << il_bits) - 64'd1))) & ((64'd1 << mem_width) - 64'd1);
  endfunction

endpackage

// File: rtl/tcdm_xbar_rr_arb.sv
// Per-bank round-robin arbiter.
//   req_i : requesters targeting this bank
//   gnt_i : bank grant; pointer advances only on req_o & gnt_i
//   req_o : at least one requester present
//   idx_o : winner, first requester at or after the pointer
module tcdm_xbar_rr_arb #(
  parameter  int unsigned NumIn = 4,
  localparam int unsigned IdxW  = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NumIn-1:0] req_i,
  input  logic             gnt_i,
  output logic             req_o,
  output logic [IdxW-1:0]  idx_o
);

  logic [IdxW-1:0] r_ptr;

  // Two passes: requesters at/after the pointer first, then the wrapped-around ones.
  always_comb begin
    req_o = 1'b0;
    idx_o = '0;
    for (int unsigned j = 0; j < NumIn; j++) begin
      if (!req_o && req_i[j] && (IdxW'(j) >= r_ptr)) begin
        req_o = 1'b1;
        idx_o = IdxW'(j);
      end
    end
    for (int unsigned j = 0; j < NumIn; j++) begin
      if (!req_o && req_i[j]) begin
        req_o = 1'b1;
        idx_o = IdxW'(j);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (req_o && gnt_i) begin
      r_ptr <= (32'(idx_o) == NumIn - 1) ? '0 : idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/tcdm_xbar_pipe.sv
// Full TCDM crossbar with configurable bank interleaving, optional request
// register per initiator and a per-bank response pipeline of depth RespLat.
//   req_i/add_i/wen_i/wdata_i/be_i : initiator requests (byte addresses)
//   gnt_o                          : initiator request accepted
//   vld_o/rdata_o                  : initiator responses, RespLat after bank handshake
//   req_o/add_o/wen_o/wdata_o/be_o : bank requests (bank-local word addresses)
//   gnt_i/rdata_i                  : bank grant and read data
module tcdm_xbar_pipe
  import tcdm_xbar_pkg::*;
#(
  parameter int unsigned NumIn           = 4,
  parameter int unsigned NumOut          = 8,
  parameter int unsigned AddrWidth       = 32,
  parameter int unsigned DataWidth       = 32,
  parameter int unsigned BeWidth         = DataWidth / 8,
  parameter int unsigned AddrMemWidth    = 12,
  parameter int unsigned InterleaveWords = 1,
  parameter int unsigned ReqPipe         = 0,
  parameter int unsigned RespLat         = 1,
  parameter int unsigned WriteRespOn     = 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumIn-1:0]                   req_i,
  input  logic [NumIn-1:0][AddrWidth-1:0]    add_i,
  input  logic [NumIn-1:0]                   wen_i,
  input  logic [NumIn-1:0][DataWidth-1:0]    wdata_i,
  input  logic [NumIn-1:0][BeWidth-1:0]      be_i,
  output logic [NumIn-1:0]                   gnt_o,
  output logic [NumIn-1:0]                   vld_o,
  output logic [NumIn-1:0][DataWidth-1:0]    rdata_o,
  output logic [NumOut-1:0]                  req_o,
  input  logic [NumOut-1:0]                  gnt_i,
  output logic [NumOut-1:0][AddrMemWidth-1:0] add_o,
  output logic [NumOut-1:0]                  wen_o,
  output logic [NumOut-1:0][DataWidth-1:0]  wdata_o,
  output logic [NumOut-1:0][BeWidth-1:0]    be_o,
  input  logic [NumOut-1:0][DataWidth-1:0]  rdata_i
);

  localparam int unsigned W    = word_offset(DataWidth);
  localparam int unsigned I    = $clog2(InterleaveWords);
  localparam int unsigned B    = bank_idx_width(NumOut);
  localparam int unsigned IdxW = (NumIn > 1) ? $clog2(NumIn) : 1;

  // Decoded incoming requests.
  logic [NumIn-1:0][B-1:0]            w_in_bank;
  logic [NumIn-1:0][AddrMemWidth-1:0] w_in_addr;

  // Requests presented to the arbiters (direct or registered).
  logic [NumIn-1:0]                   w_ireq;
  logic [NumIn-1:0][B-1:0]            w_ibank;
  logic [NumIn-1:0][AddrMemWidth-1:0] w_iaddr;
  logic [NumIn-1:0]                   w_iwen;
  logic [NumIn-1:0][DataWidth-1:0]    w_iwdata;
  logic [NumIn-1:0][BeWidth-1:0]      w_ibe;

  logic [NumOut-1:0][IdxW-1:0]        w_win;
  logic [NumOut-1:0]                  w_hs;
  logic [NumIn-1:0]                   w_igrant;
  resp_tag_t [NumOut-1:0]             w_last;

  always_comb begin
    w_in_bank = '0;
    w_in_addr = '0;
    for (int i = 0; i < NumIn; i++) begin
      w_in_bank[i] = B'(addr_bank(64'(add_i[i]), W, I, B));
      w_in_addr[i] = AddrMemWidth'(addr_mem(64'(add_i[i]), W, I, B, AddrMemWidth));
    end
  end

  if (ReqPipe != 0) begin : g_req_pipe
    logic [NumIn-1:0]                   r_full;
    logic [NumIn-1:0][B-1:0]            r_bank;
    logic [NumIn-1:0][AddrMemWidth-1:0] r_addr;
    logic [NumIn-1:0]                   r_wen;
    logic [NumIn-1:0][DataWidth-1:0]    r_wdata;
    logic [NumIn-1:0][BeWidth-1:0]      r_be;

    // Accept when empty or when the held entry leaves this cycle; gnt_i only
    // reaches gnt_o through a full register.
    assign gnt_o = req_i & (~r_full | w_igrant);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_full  <= '0;
        r_bank  <= '0;
        r_addr  <= '0;
        r_wen   <= '0;
        r_wdata <= '0;
        r_be    <= '0;
      end else begin
        for (int i = 0; i < NumIn; i++) begin
          if (gnt_o[i]) begin
            r_full[i]  <= 1'b1;
            r_bank[i]  <= w_in_bank[i];
            r_addr[i]  <= w_in_addr[i];
            r_wen[i]   <= wen_i[i];
            r_wdata[i] <= wdata_i[i];
            r_be[i]    <= be_i[i];
          end else if (w_igrant[i]) begin
            r_full[i] <= 1'b0;
          end
        end
      end
    end

    assign w_ireq   = r_full;
    assign w_ibank  = r_bank;
    assign w_iaddr  = r_addr;
    assign w_iwen   = r_wen;
    assign w_iwdata = r_wdata;
    assign w_ibe    = r_be;

    for (genvar i = 0; i < NumIn; i++) begin : g_hold_chk
      a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
          (r_full[i] && !w_igrant[i]) |=>
          $stable({r_bank[i], r_addr[i], r_wen[i], r_wdata[i], r_be[i]}));
    end
  end else begin : g_req_comb
    assign gnt_o    = w_igrant;
    assign w_ireq   = req_i;
    assign w_ibank  = w_in_bank;
    assign w_iaddr  = w_in_addr;
    assign w_iwen   = wen_i;
    assign w_iwdata = wdata_i;
    assign w_ibe    = be_i;
  end

  assign w_hs = req_o & gnt_i;

  always_comb begin
    w_igrant = '0;
    for (int k = 0; k < NumOut; k++) begin
      if (w_hs[k]) w_igrant[w_win[k]] = 1'b1;
    end
  end

  for (genvar k = 0; k < NumOut; k++) begin : g_bank
    logic [NumIn-1:0]         w_bank_req;
    resp_tag_t [RespLat-1:0]  r_pipe;

    always_comb begin
      w_bank_req = '0;
      for (int i = 0; i < NumIn; i++) begin
        w_bank_req[i] = w_ireq[i] && (w_ibank[i] == B'(k));
      end
    end

    tcdm_xbar_rr_arb #(
      .NumIn(NumIn)
    ) u_arb (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .req_i (w_bank_req),
      .gnt_i (gnt_i[k]),
      .req_o (req_o[k]),
      .idx_o (w_win[k])
    );

    assign add_o[k]   = w_iaddr[w_win[k]];
    assign wen_o[k]   = w_iwen[w_win[k]];
    assign wdata_o[k] = w_iwdata[w_win[k]];
    assign be_o[k]    = w_ibe[w_win[k]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_pipe <= '0;
      end else begin
        r_pipe[0] <= '{valid: w_hs[k], idx: MaxIdxWidth'(w_win[k]), wen: wen_o[k]};
        for (int s = 1; s < RespLat; s++) r_pipe[s] <= r_pipe[s-1];
      end
    end

    assign w_last[k] = r_pipe[RespLat-1];
  end

  // An initiator completes at most one handshake per cycle, so at most one
  // bank returns to it per cycle.
  always_comb begin
    vld_o   = '0;
    rdata_o = '0;
    for (int k = 0; k < NumOut; k++) begin
      for (int i = 0; i < NumIn; i++) begin
        if (w_last[k].valid && (w_last[k].idx == MaxIdxWidth'(i))) begin
          if (!w_last[k].wen || (WriteRespOn != 0)) vld_o[i] = 1'b1;
          if (!w_last[k].wen) rdata_o[i] = rdata_i[k];
        end
      end
    end
  end

  a_addr_fits: assert property (@(posedge clk_i) AddrMemWidth + B + I + W <= AddrWidth);
  a_out_pow2:  assert property (@(posedge clk_i) (NumOut & (NumOut - 1)) == 0);
  a_il_pow2:   assert property (@(posedge clk_i) (InterleaveWords & (InterleaveWords - 1)) == 0);
  a_lat_min:   assert property (@(posedge clk_i) RespLat >= 1);
  a_idx_fits:  assert property (@(posedge clk_i) IdxW <= MaxIdxWidth);

endmodule

// File: tb/tb_tcdm_xbar_pipe.sv
// Two crossbar instances share one randomized stimulus stream:
//   dut0: ReqPipe=0, RespLat=1, InterleaveWords=1, WriteRespOn=1
//   dut1: ReqPipe=1, RespLat=3, InterleaveWords=4, WriteRespOn=0
// Each cycle outputs are compared against a transaction-level reference model.
module tb_tcdm_xbar_pipe;

  localparam int NI = 4, NO = 8, AW = 32, DW = 32, BW = 4, AMW = 12, ND = 2;
  localparam int NCYC = 2400;

  function automatic int rp_of(input int d);  return (d == 0) ? 0 : 1; endfunction
  function automatic int rl_of(input int d);  return (d == 0) ? 1 : 3; endfunction
  function automatic int il_of(input int d);  return (d == 0) ? 1 : 4; endfunction
  function automatic int wro_of(input int d); return (d == 0) ? 1 : 0; endfunction

  logic clk = 1'b0;
  logic rst_n;
  logic [NI-1:0]         req, wen;
  logic [NI-1:0][AW-1:0] add;
  logic [NI-1:0][DW-1:0] wdata;
  logic [NI-1:0][BW-1:0] be;
  logic [NO-1:0]         bgnt;
  logic [NO-1:0][DW-1:0] rdata;

  logic [NI-1:0]          gnt_s  [ND];
  logic [NI-1:0]          vld_s  [ND];
  logic [NI-1:0][DW-1:0]  rdo_s  [ND];
  logic [NO-1:0]          breq_s [ND];
  logic [NO-1:0]          bwen_s [ND];
  logic [NO-1:0][AMW-1:0] badd_s [ND];
  logic [NO-1:0][DW-1:0]  bwd_s  [ND];
  logic [NO-1:0][BW-1:0]  bbe_s  [ND];

  always #5 clk = ~clk;

  tcdm_xbar_pipe #(
    .NumIn(NI), .NumOut(NO), .AddrWidth(AW), .DataWidth(DW), .BeWidth(BW),
    .AddrMemWidth(AMW), .InterleaveWords(1), .ReqPipe(0), .RespLat(1), .WriteRespOn(1)
  ) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
    .be_i(be), .gnt_o(gnt_s[0]), .vld_o(vld_s[0]), .rdata_o(rdo_s[0]), .req_o(breq_s[0]),
    .gnt_i(bgnt), .add_o(badd_s[0]), .wen_o(bwen_s[0]), .wdata_o(bwd_s[0]),
    .be_o(bbe_s[0]), .rdata_i(rdata)
  );

  tcdm_xbar_pipe #(
    .NumIn(NI), .NumOut(NO), .AddrWidth(AW), .DataWidth(DW), .BeWidth(BW),
    .AddrMemWidth(AMW), .InterleaveWords(4), .ReqPipe(1), .RespLat(3), .WriteRespOn(0)
  ) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
    .be_i(be), .gnt_o(gnt_s[1]), .vld_o(vld_s[1]), .rdata_o(rdo_s[1]), .req_o(breq_s[1]),
    .gnt_i(bgnt), .add_o(badd_s[1]), .wen_o(bwen_s[1]), .wdata_o(bwd_s[1]),
    .be_o(bbe_s[1]), .rdata_i(rdata)
  );

  // Reference model state.
  int            rr       [ND][NO];
  bit            h_v      [ND][NI];
  int            h_bank   [ND][NI];
  int            h_addr   [ND][NI];
  bit            h_wen    [ND][NI];
  logic [DW-1:0] h_wd     [ND][NI];
  logic [BW-1:0] h_be     [ND][NI];
  bit            due_v    [ND][8][NI];
  int            due_bank [ND][8][NI];
  bit            due_wen  [ND][8][NI];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Word-granular view of the address map.
  function automatic int bank_of(input int d, input logic [AW-1:0] a);
    int unsigned word;
    word = a / 4;
    return int'((word / il_of(d)) % NO);
  endfunction

  function automatic int maddr_of(input int d, input logic [AW-1:0] a);
    int unsigned word;
    word = a / 4;
    return int'(((word / (il_of(d) * NO)) * il_of(d) + word % il_of(d)) % (1 << AMW));
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      for (int k = 0; k < NO; k++) rr[d][k] = 0;
      for (int i = 0; i < NI; i++) begin
        h_v[d][i] = 0;
        for (int s = 0; s < 8; s++) due_v[d][s][i] = 0;
      end
    end
  endtask

  task automatic step(input int d, input int cyc);
    bit            ev [NI];
    int            eb [NI];
    int            ea [NI];
    bit            ew [NI];
    logic [DW-1:0] ed [NI];
    logic [BW-1:0] ee [NI];
    bit            ig [NI];
    int            win[NO];
    logic [NI-1:0] x_gnt, x_vld;
    logic [NO-1:0] x_req;
    logic [DW-1:0] x_rd;
    int            slot, s2, j;
    slot = cyc % 8;
    for (int i = 0; i < NI; i++) begin
      if (rp_of(d) == 0) begin
        ev[i] = req[i]; eb[i] = bank_of(d, add[i]); ea[i] = maddr_of(d, add[i]);
        ew[i] = wen[i]; ed[i] = wdata[i]; ee[i] = be[i];
      end else begin
        ev[i] = h_v[d][i]; eb[i] = h_bank[d][i]; ea[i] = h_addr[d][i];
        ew[i] = h_wen[d][i]; ed[i] = h_wd[d][i]; ee[i] = h_be[d][i];
      end
      ig[i] = 0;
    end
    x_req = '0;
    for (int k = 0; k < NO; k++) begin
      win[k] = -1;
      for (int off = 0; off < NI; off++) begin
        j = (rr[d][k] + off) % NI;
        if (win[k] < 0 && ev[j] && eb[j] == k) win[k] = j;
      end
      if (win[k] >= 0) begin
        x_req[k] = 1'b1;
        if (bgnt[k]) ig[win[k]] = 1;
      end
    end
    for (int i = 0; i < NI; i++) begin
      x_gnt[i] = (rp_of(d) == 0) ? ig[i] : (req[i] && (!h_v[d][i] || ig[i]));
      x_vld[i] = due_v[d][slot][i] && (!due_wen[d][slot][i] || wro_of(d) != 0);
      x_rd = (due_v[d][slot][i] && !due_wen[d][slot][i]) ? rdata[due_bank[d][slot][i]] : '0;
      check_eq($sformatf("dut%0d cyc%0d rdata_o[%0d]", d, cyc, i), rdo_s[d][i], x_rd);
    end
    check_eq($sformatf("dut%0d cyc%0d gnt_o", d, cyc), gnt_s[d], x_gnt);
    check_eq($sformatf("dut%0d cyc%0d vld_o", d, cyc), vld_s[d], x_vld);
    check_eq($sformatf("dut%0d cyc%0d req_o", d, cyc), breq_s[d], x_req);
    for (int k = 0; k < NO; k++) begin
      if (win[k] >= 0) begin
        check_eq($sformatf("dut%0d cyc%0d add_o[%0d]", d, cyc, k), badd_s[d][k], ea[win[k]]);
        check_eq($sformatf("dut%0d cyc%0d wen_o[%0d]", d, cyc, k), bwen_s[d][k], ew[win[k]]);
        check_eq($sformatf("dut%0d cyc%0d wdata_o[%0d]", d, cyc, k), bwd_s[d][k], ed[win[k]]);
        check_eq($sformatf("dut%0d cyc%0d be_o[%0d]", d, cyc, k), bbe_s[d][k], ee[win[k]]);
      end
    end
    // Advance to the next clock edge.
    for (int i = 0; i < NI; i++) due_v[d][slot][i] = 0;
    for (int k = 0; k < NO; k++) begin
      if (win[k] >= 0 && bgnt[k]) begin
        s2 = (cyc + rl_of(d)) % 8;
        due_v[d][s2][win[k]]    = 1;
        due_bank[d][s2][win[k]] = k;
        due_wen[d][s2][win[k]]  = ew[win[k]];
        rr[d][k] = (win[k] + 1) % NI;
      end
    end
    if (rp_of(d) != 0) begin
      for (int i = 0; i < NI; i++) begin
        if (x_gnt[i]) begin
          h_v[d][i] = 1; h_bank[d][i] = bank_of(d, add[i]); h_addr[d][i] = maddr_of(d, add[i]);
          h_wen[d][i] = wen[i]; h_wd[d][i] = wdata[i]; h_be[d][i] = be[i];
        end else if (ig[i]) begin
          h_v[d][i] = 0;
        end
      end
    end
  endtask

  task automatic drive_random();
    for (int i = 0; i < NI; i++) begin
      add[i]   = $urandom;
      wdata[i] = $urandom;
      be[i]    = BW'($urandom);
    end
    for (int k = 0; k < NO; k++) rdata[k] = $urandom;
    req  = NI'($urandom);
    wen  = NI'($urandom);
    bgnt = NO'(~($urandom & $urandom));
  endtask

  initial begin
    logic [AW-1:0] il_tab [4];
    il_tab[0] = 32'h00; il_tab[1] = 32'h04; il_tab[2] = 32'h0C; il_tab[3] = 32'h10;
    rst_n = 1'b0;
    req = '0; wen = '0; add = '0; wdata = '0; be = '0; bgnt = '0; rdata = '0;
    model_reset();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      drive_random();
      if (cyc < 3 || (cyc % 200) == 100 || (cyc % 200) == 101) begin
        rst_n = 1'b0;
        req   = '0;
        model_reset();
      end else begin
        rst_n = 1'b1;
        if (cyc == 3) begin
          // Single load of byte address 0x10 from initiator 0.
          req = 4'b0001; add[0] = 32'h10; wen = '0; bgnt = '1;
        end else if (cyc == 4) begin
          rdata[4] = 32'hCAFE_0001;
        end else if (cyc >= 10 && cyc < 40) begin
          // Every initiator loads the same bank with spare upper address bits.
          req = '1; wen = '0; bgnt = '1;
          for (int i = 0; i < NI; i++) add[i] = ($urandom & 32'hFFFE_0000) | 32'h28;
        end else if (cyc >= 40 && cyc < 60) begin
          req = '1;
          for (int i = 0; i < NI; i++) add[i] = il_tab[i];
        end else if (cyc >= 60 && cyc < 90) begin
          // Long backpressure on bank 3 plus occasional full stalls.
          bgnt[3] = 1'b0;
          if ((cyc % 7) < 2) bgnt = '0;
        end
      end
      @(negedge clk);
      for (int d = 0; d < ND; d++) step(d, cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
